// File: rtl/soc_tcm_fabric.sv
// soc_tcm_fabric
//   Owns the ITCM and DTCM arrays. Connects them to the core instruction and
//   data ports, and to a handshaked loader that fills either TCM while the
//   core is held.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   i_addr / i_rdata               instruction fetch, byte address in, 1-cycle read
//   d_addr/d_wdata/d_wstrb/d_we/d_re  core data access
//   d_rdata / d_err                load data (1-cycle) and access-error pulse
//   ld_start/ld_valid/ld_ready     loader session start and beat handshake
//   ld_sel/ld_addr/ld_data/ld_last beat target (0 ITCM, 1 DTCM), word index, data, last
//   ld_cnt                         beats accepted in current session (saturating)
//   core_hold                      core stall request while a session is active
module soc_tcm_fabric #(
  parameter int          IAW       = 12,
  parameter int          DAW       = 12,
  parameter logic [31:0] DTCM_BASE = 32'h0001_0000,
  parameter logic [31:0] HOLD_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_we,
  input  logic        d_re,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [15:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic [15:0] ld_cnt,
  output logic        core_hold
);

  localparam int          IDEPTH  = 1 << IAW;
  localparam int          DDEPTH  = 1 << DAW;
  localparam logic [31:0] DBASE_HI = DTCM_BASE >> (DAW + 2);

  logic [31:0] itcm [IDEPTH];
  logic [31:0] dtcm [DDEPTH];

  // ---------------- loader FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic        ld_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    core_hold = 1'b0;
    ld_ready  = 1'b0;
    ld_beat   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d  = S_LOAD;
          ld_cnt_d = 16'd0;
        end
      end
      S_LOAD: begin
        core_hold = 1'b1;
        ld_ready  = 1'b1;
        if (ld_valid) begin
          ld_beat = 1'b1;
          if (ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
          if (ld_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        core_hold = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_cnt = ld_cnt_q;

  // ---------------- address decode ----------------
  logic           i_hit, d_ihit, d_dhit;
  logic [IAW-1:0] i_idx, d_iidx, ld_iidx;
  logic [DAW-1:0] d_didx, ld_didx;
  logic           core_rd, core_wr;

  assign i_hit  = (i_addr >> (IAW + 2)) == 32'd0;
  assign d_ihit = (d_addr >> (IAW + 2)) == 32'd0;
  assign d_dhit = (d_addr >> (DAW + 2)) == DBASE_HI;
  assign i_idx  = i_addr[IAW+1:2];
  assign d_iidx = d_addr[IAW+1:2];
  assign d_didx = d_addr[DAW+1:2];
  // Loader index wraps modulo the target memory depth.
  assign ld_iidx = IAW'(ld_addr);
  assign ld_didx = DAW'(ld_addr);

  logic ld_addr_unused;
  assign ld_addr_unused = ^ld_addr;

  // The core is locked out entirely while held; an all-zero strobe is a no-op.
  assign core_rd = d_re & ~core_hold;
  assign core_wr = d_we & ~core_hold & (|d_wstrb);

  // ---------------- memory writes ----------------
  // Loader and core never write in the same cycle: core_wr is gated by hold.
  always_ff @(posedge clk) begin
    if (ld_beat && !ld_sel) itcm[ld_iidx] <= ld_data;
    if (ld_beat && ld_sel) begin
      dtcm[ld_didx] <= ld_data;
    end else if (core_wr && d_dhit) begin
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) dtcm[d_didx][8*b +: 8] <= d_wdata[8*b +: 8];
    end
  end

  // ---------------- read ports ----------------
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  always_comb begin
    i_rdata_d = 32'd0;
    if (core_hold)  i_rdata_d = HOLD_INSN;
    else if (i_hit) i_rdata_d = itcm[i_idx];

    // Array read sees pre-edge contents, giving read-before-write for free.
    d_rdata_d = d_rdata_q;
    if (core_rd) begin
      if (d_dhit)      d_rdata_d = dtcm[d_didx];
      else if (d_ihit) d_rdata_d = itcm[d_iidx];
      else             d_rdata_d = 32'd0;
    end

    // Stores are only legal into DTCM; ITCM is read-only to the core.
    d_err_d = (core_rd & ~d_ihit & ~d_dhit) | (core_wr & ~d_dhit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      d_err_q   <= 1'b0;
    end else begin
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_soc_tcm_fabric.sv
module tb_soc_tcm_fabric;

  localparam int          DAW = 12;
  localparam logic [31:0] DB  = 32'h0001_0000;

  localparam int S_IRD = 0, S_DRD = 1, S_ERR = 2, S_CNT = 3, S_HOLD = 4, S_RDY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, ld_data;
  logic [3:0]  d_wstrb;
  logic        d_we, d_re, d_err, ld_start, ld_valid, ld_ready, ld_sel, ld_last, core_hold;
  logic [15:0] ld_addr, ld_cnt;

  soc_tcm_fabric #(.IAW(12), .DAW(DAW), .DTCM_BASE(DB), .HOLD_INSN(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_we(d_we), .d_re(d_re),
    .d_rdata(d_rdata), .d_err(d_err),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ld_cnt(ld_cnt),
    .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_at(input int due, input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_IRD:   return i_rdata;
      S_DRD:   return d_rdata;
      S_ERR:   return {31'd0, d_err};
      S_CNT:   return {16'd0, ld_cnt};
      S_HOLD:  return {31'd0, core_hold};
      default: return {31'd0, ld_ready};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].due == cyc) begin
        logic [31:0] act;
        act = pick(sbq[k].sel);
        checks++;
        if (act !== sbq[k].exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sbq[k].name, act, sbq[k].exp, cyc);
        end
        sbq.delete(k);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_we = 0; d_re = 0;
    ld_start = 0; ld_valid = 0; ld_sel = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    step(2);
    expect_at(cyc, S_IRD, 32'h0, "rst_i_rdata");
    expect_at(cyc, S_DRD, 32'h0, "rst_d_rdata");
    expect_at(cyc, S_ERR, 32'h0, "rst_d_err");
    expect_at(cyc, S_CNT, 32'h0, "rst_ld_cnt");
    expect_at(cyc, S_HOLD, 32'h0, "rst_hold");
    expect_at(cyc, S_RDY, 32'h0, "rst_ready");
    checks++;
    if (core_hold !== 1'b0 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct: hold=%b ready=%b expected 0/0", core_hold, ld_ready);
    end
    step; rst = 1'b0; step;

    d_we = 1; d_addr = DB; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    expect_at(cyc + 1, S_ERR, 32'h0, "seed_no_err");
    step; d_we = 0;

    ld_start = 1; step; ld_start = 0;
    expect_at(cyc, S_HOLD, 32'h1, "load_hold");
    expect_at(cyc, S_RDY, 32'h1, "load_ready");
    expect_at(cyc, S_CNT, 32'h0, "cnt_cleared");
    checks++;
    if (core_hold !== 1'b1 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_direct: hold=%b ready=%b expected 1/1", core_hold, ld_ready);
    end
    ld_valid = 1; ld_sel = 0; ld_addr = 16'd0; ld_data = 32'h11;
    i_addr = 32'h0;
    d_we = 1; d_addr = DB; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    expect_at(cyc + 1, S_IRD, 32'h0000_0013, "hold_nop");
    expect_at(cyc + 1, S_ERR, 32'h0, "hold_no_err");
    step; d_we = 0;
    ld_addr = 16'd1; ld_data = 32'h22;
    expect_at(cyc, S_CNT, 32'h1, "cnt_1");
    step;
    ld_addr = 16'd2; ld_data = 32'h33; ld_last = 1;
    step; ld_valid = 0; ld_last = 0;
    expect_at(cyc, S_HOLD, 32'h1, "drain_hold");
    expect_at(cyc, S_RDY, 32'h0, "drain_ready");
    expect_at(cyc, S_CNT, 32'h3, "cnt_3");
    checks++;
    if (ld_cnt !== 16'd3) begin
      failures++;
      $display("FAIL cnt_direct: got %h expected 0003", ld_cnt);
    end
    step;
    expect_at(cyc, S_HOLD, 32'h0, "idle_hold");
    expect_at(cyc, S_CNT, 32'h3, "cnt_kept");
    i_addr = 32'd8; d_re = 1; d_addr = DB;
    expect_at(cyc + 1, S_IRD, 32'h33, "itcm_fetch");
    expect_at(cyc + 1, S_DRD, 32'h1234_5678, "held_store_dropped");
    step; d_re = 0;
    checks++;
    if (i_rdata !== 32'h33) begin
      failures++;
      $display("FAIL fetch_direct: got %h expected 00000033", i_rdata);
    end

    d_we = 1; d_addr = DB; d_wdata = 32'hAABB_CCDD; d_wstrb = 4'hF; step;
    d_wdata = 32'h0000_0011; d_wstrb = 4'b0001; step;
    d_we = 0; d_re = 1;
    expect_at(cyc + 1, S_DRD, 32'hAABB_CC11, "strobe_merge");
    step; d_re = 0;
    checks++;
    if (d_rdata !== 32'hAABB_CC11) begin
      failures++;
      $display("FAIL strobe_direct: got %h expected aabbcc11", d_rdata);
    end
    expect_at(cyc + 1, S_DRD, 32'hAABB_CC11, "rdata_holds");
    step;

    d_re = 1; d_addr = 32'h4000_0000;
    expect_at(cyc + 1, S_DRD, 32'h0, "unmap_rdata");
    expect_at(cyc + 1, S_ERR, 32'h1, "unmap_err");
    step;
    checks++;
    if (d_err !== 1'b1) begin
      failures++;
      $display("FAIL unmap_err_direct: got %b expected 1", d_err);
    end
    d_re = 0; d_we = 1; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
    expect_at(cyc + 1, S_ERR, 32'h1, "itcm_store_err");
    step;
    d_we = 0; d_re = 1; d_addr = 32'h0;
    expect_at(cyc + 1, S_DRD, 32'h11, "itcm_unchanged");
    expect_at(cyc + 1, S_ERR, 32'h0, "err_one_cycle");
    step; d_re = 0;
    d_we = 1; d_addr = 32'h4000_0000; d_wstrb = 4'h0;
    expect_at(cyc + 1, S_ERR, 32'h0, "zero_strb_no_err");
    step; d_we = 0;

    d_addr = DB + 32'd16; d_we = 1; d_wdata = 32'd5; d_wstrb = 4'hF; step;
    d_re = 1; d_wdata = 32'd9;
    expect_at(cyc + 1, S_DRD, 32'd5, "rbw_old");
    step; d_we = 0;
    expect_at(cyc + 1, S_DRD, 32'd9, "rbw_new");
    step; d_re = 0;

    ld_start = 1; step; ld_start = 0;
    ld_valid = 1; ld_sel = 1; ld_addr = 16'd10; ld_data = 32'hA0; step;
    ld_addr = 16'd11; ld_data = 32'hA1; step;
    ld_valid = 0; rst = 1'b1;
    expect_at(cyc, S_HOLD, 32'h0, "midrst_hold");
    expect_at(cyc, S_CNT, 32'h0, "midrst_cnt");
    expect_at(cyc, S_RDY, 32'h0, "midrst_ready");
    step; rst = 1'b0; step;
    d_re = 1; d_addr = DB + 32'd40;
    expect_at(cyc + 1, S_DRD, 32'hA0, "persist_0");
    step; d_addr = DB + 32'd44;
    expect_at(cyc + 1, S_DRD, 32'hA1, "persist_1");
    step; d_re = 0;

    ld_start = 1; step; ld_start = 0;
    ld_valid = 1; ld_sel = 1; ld_addr = 16'((1 << DAW) + 1); ld_data = 32'hCAFE_F00D; ld_last = 1;
    step; ld_valid = 0; ld_last = 0;
    expect_at(cyc, S_CNT, 32'h1, "wrap_cnt");
    step;
    d_re = 1; d_addr = DB + 32'd4;
    expect_at(cyc + 1, S_DRD, 32'hCAFE_F00D, "wrap_word1");
    step; d_re = 0;
    checks++;
    if (d_rdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL wrap_direct: got %h expected cafef00d", d_rdata);
    end
    step(3);

    foreach (sbq[k]) begin
      checks++;
      failures++;
      $display("FAIL %s: never compared, expected %h at cycle %0d", sbq[k].name, sbq[k].exp, sbq[k].due);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
